coprocessor0: RTL and testbench
===============================

# coprocessor0

System control coprocessor (CP0) for the Minisys-1A core: the receiving end of the exception, mtc0/mfc0 and eret signalling produced by instruction decode. It holds Status, Cause, EPC, Count and Compare, and arbitrates synchronous exceptions, external and timer interrupts, and eret. On an accepted event it emits a one-cycle PC redirect to fetch, then holds a short flush window.

## Interface
- EXC_VECTOR, 32'h0000_F000, PC loaded on exception or interrupt entry
- FLUSH_CYCLES, 2, cycles (≥1) during which new requests are ignored after a redirect
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- exc_valid  in  1  synchronous exception request from decode
- exc_code  in  5  cause code: 8 syscall, 9 break, 10 reserved instr, 12 overflow; 5'b11111 = none
- exc_pc  in  32  PC of the instruction currently in decode; used for EPC
- mtc0  in  1  write CP0 register
- mfc0  in  1  read CP0 register (qualifies rdata only)
- eret  in  1  return from exception
- cp0_addr  in  5  CP0 register number (rd field)
- wdata  in  32  mtc0 data (rt value)
- int_in  in  6  external interrupt lines, level-sensitive
- rdata  out  32  mfc0 data, combinational
- redirect  out  1  registered one-cycle PC-redirect pulse
- redirect_pc  out  32  target PC, valid while redirect=1
- timer_int  out  1  Count==Compare pending flag
- exl  out  1  Status.EXL

## Operation
- Registers and reset values: Status (12) = 32'h0000_FF01 (IE[0]=1, EXL[1]=0, IM[15:8]=FF); Cause (13) = 0 (ExcCode[6:2], IP[15:8]); EPC (14) = 0; Count (9) = 0; Compare (11) = 32'hFFFF_FFFF; timer_int = 0; redirect = 0; redirect_pc = 0; FSM = NORMAL.
- Cause.IP[7:2] is reloaded every cycle with {int_in[5] | timer_int, int_in[4:0]}. IP[1:0] are software bits, written only by mtc0.
- Count increments every cycle and wraps FFFF_FFFF→0. Count==Compare sets timer_int, which stays set until mtc0 writes Compare.
- An exception is valid when exc_valid=1 and exc_code≠11111. exc_code 11111 with exc_valid=1 is ignored.
- An interrupt is pending when IE=1, EXL=0 and (IP & IM)≠0.
- Priority in NORMAL: exception > interrupt > eret > mtc0. The lower-priority requests in the same cycle are dropped.
- Exception or interrupt entry:
  - ExcCode ← exc_code, or 0 for an interrupt.
  - EPC ← exc_pc, but only if EXL was 0.
  - EXL ← 1.
  - redirect_pc ← EXC_VECTOR.
- eret: EXL ← 0, redirect_pc ← EPC.
- mtc0 write masks:
  - Status: only IE, EXL, IM are written.
  - Cause: only IP[1:0].
  - EPC, Count, Compare: all 32 bits.
  - Any other address: write ignored.
- mfc0: rdata = addressed register; unmapped address → 0; rdata = 0 when mfc0=0.
- FSM states:
  - NORMAL → FLUSH on an accepted exception, interrupt or eret.
  - FLUSH lasts FLUSH_CYCLES cycles, then → NORMAL.
  - In FLUSH, exc_valid, eret and mtc0 are ignored. Interrupts remain pending (level) and are taken in NORMAL.

## Timing
- A request sampled at edge N updates the registers at edge N. redirect=1 for exactly cycle N+1, and FLUSH covers cycles N+1 … N+FLUSH_CYCLES.
- Register values are visible on rdata from cycle N+1.
- mtc0 Count in the same cycle as the increment: the written value wins, with no increment that cycle.
- mtc0 Compare in the same cycle as a match: timer_int is cleared, the write wins.
- Exception plus mtc0 in the same cycle: the mtc0 is lost.
- Exception while EXL=1: EPC is held, ExcCode is updated, redirect still fires.
- Reset mid-FLUSH: immediate return to NORMAL with all reset values, and redirect=0 in the next cycle.

## Structure
- cp0_pkg holds:
  - register numbers (9, 11, 12, 13, 14)
  - ExcCode constants (0, 8, 9, 10, 12, 31)
  - Status/Cause bit positions
  - FSM state enum {NORMAL, FLUSH}
- Sub-module cp0_timer holds Count, Compare, the match logic and timer_int, with its write-enable inputs.

## Test plan
- Reset, then mfc0 addr 12/13/14/11 → rdata 0000_FF01 / 0 / 0 / FFFF_FFFF. redirect stays 0.
- exc_valid=1, code 8, exc_pc 0000_0040 → next cycle redirect=1, redirect_pc 0000_F000. EPC=0000_0040, Cause[6:2]=8, exl=1. A second exc_valid in the next cycle is ignored.
- After the above, eret → redirect_pc 0000_0040, exl=0. eret plus exc_valid in the same cycle → exception taken.
- mtc0 Compare=0000_0010, Count=0, int IE=1 → timer_int after 16 cycles, interrupt entry with ExcCode 0. mtc0 Compare clears timer_int.
- int_in=6'b000001 with IM[2]=0 → no entry. Set IM[2]=1 via mtc0 Status → entry two cycles later; EPC = exc_pc at acceptance.
- Reset asserted during FLUSH → NORMAL, registers at reset values, eret the next cycle → redirect_pc 0.

Source files
------------

// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, exception codes,
// Status/Cause field positions and the control FSM states.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_NONE = 5'd31;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;

  typedef enum logic {
    NORMAL,
    FLUSH
  } cp0_state_t;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer; timer_int latches on a match
// and is cleared only by a Compare write.
module cp0_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tint_q, tint_d;

  always_comb begin
    count_d   = count_we ? wdata : count_q + 32'd1;
    compare_d = compare_we ? wdata : compare_q;
    tint_d    = compare_we ? 1'b0
                           : (tint_q | (count_q == compare_q));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= 32'hFFFF_FFFF;
      tint_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tint_q    <= tint_d;
    end
  end

  assign count     = count_q;
  assign compare   = compare_q;
  assign timer_int = tint_q;

endmodule

// File: rtl/coprocessor0.sv
// Minisys-1A system control coprocessor: exception/interrupt
// arbitration, eret, mtc0/mfc0 and the post-redirect flush window.
module coprocessor0
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_F000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        mtc0,
  input  logic        mfc0,
  input  logic        eret,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] wdata,
  input  logic [5:0]  int_in,
  output logic [31:0] rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        timer_int,
  output logic        exl
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  cp0_state_t  state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic [7:0]  im_q, im_d;
  logic [4:0]  code_q, code_d;
  logic [5:0]  iphw_q, iphw_d;
  logic [1:0]  ipsw_q, ipsw_d;
  logic [31:0] epc_q, epc_d;
  logic        redir_q, redir_d;
  logic [31:0] rpc_q, rpc_d;

  logic        normal, exc_take, int_pend, int_take;
  logic        eret_take, wr_take;
  logic [31:0] count, compare, status_w, cause_w;

  cp0_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .count_we   (wr_take && cp0_addr == REG_COUNT),
    .compare_we (wr_take && cp0_addr == REG_COMPARE),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .timer_int  (timer_int)
  );

  assign status_w = {16'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_w  = {16'b0, iphw_q, ipsw_q, 1'b0, code_q, 2'b0};

  // Strict priority: exception > interrupt > eret > mtc0
  always_comb begin
    normal    = (state_q == NORMAL);
    exc_take  = normal && exc_valid && (exc_code != EXC_NONE);
    int_pend  = ie_q && !exl_q && |({iphw_q, ipsw_q} & im_q);
    int_take  = normal && !exc_take && int_pend;
    eret_take = normal && !exc_take && !int_pend && eret;
    wr_take   = normal && !exc_take && !int_pend && !eret && mtc0;
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    ie_d    = ie_q;
    exl_d   = exl_q;
    im_d    = im_q;
    code_d  = code_q;
    iphw_d  = {int_in[5] | timer_int, int_in[4:0]};
    ipsw_d  = ipsw_q;
    epc_d   = epc_q;
    redir_d = 1'b0;
    rpc_d   = rpc_q;
    if (state_q == FLUSH) begin
      fcnt_d = fcnt_q - FW'(1);
      if (fcnt_q == '0) state_d = NORMAL;
    end
    unique case (1'b1)
      exc_take, int_take: begin
        code_d  = exc_take ? exc_code : EXC_INT;
        if (!exl_q) epc_d = exc_pc;
        exl_d   = 1'b1;
        redir_d = 1'b1;
        rpc_d   = EXC_VECTOR;
        state_d = FLUSH;
        fcnt_d  = FW'(FLUSH_CYCLES - 1);
      end
      eret_take: begin
        exl_d   = 1'b0;
        redir_d = 1'b1;
        rpc_d   = epc_q;
        state_d = FLUSH;
        fcnt_d  = FW'(FLUSH_CYCLES - 1);
      end
      wr_take: begin
        case (cp0_addr)
          REG_STATUS: begin
            ie_d  = wdata[ST_IE];
            exl_d = wdata[ST_EXL];
            im_d  = wdata[ST_IM_LO +: 8];
          end
          REG_CAUSE: ipsw_d = wdata[CA_IP_LO +: 2];
          REG_EPC:   epc_d  = wdata;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= NORMAL;
      fcnt_q  <= '0;
      ie_q    <= 1'b1;
      exl_q   <= 1'b0;
      im_q    <= 8'hFF;
      code_q  <= '0;
      iphw_q  <= '0;
      ipsw_q  <= '0;
      epc_q   <= '0;
      redir_q <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      ie_q    <= ie_d;
      exl_q   <= exl_d;
      im_q    <= im_d;
      code_q  <= code_d;
      iphw_q  <= iphw_d;
      ipsw_q  <= ipsw_d;
      epc_q   <= epc_d;
      redir_q <= redir_d;
      rpc_q   <= rpc_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (mfc0) begin
      case (cp0_addr)
        REG_COUNT:   rdata = count;
        REG_COMPARE: rdata = compare;
        REG_STATUS:  rdata = status_w;
        REG_CAUSE:   rdata = cause_w;
        REG_EPC:     rdata = epc_q;
        default:     rdata = '0;
      endcase
    end
  end

  assign redirect    = redir_q;
  assign redirect_pc = rpc_q;
  assign exl         = exl_q;

endmodule

// File: tb/tb_coprocessor0.sv
// Self-checking bench for coprocessor0: directed stimulus with
// a redirect scoreboard (target PC and cycle of each pulse).
module tb_coprocessor0;

  logic        clock = 1'b0;
  logic        reset;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        mtc0, mfc0, eret;
  logic [4:0]  cp0_addr;
  logic [31:0] wdata;
  logic [5:0]  int_in;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        timer_int, exl;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   base;

  coprocessor0 dut (
    .clock       (clock),
    .reset       (reset),
    .exc_valid   (exc_valid),
    .exc_code    (exc_code),
    .exc_pc      (exc_pc),
    .mtc0        (mtc0),
    .mfc0        (mfc0),
    .eret        (eret),
    .cp0_addr    (cp0_addr),
    .wdata       (wdata),
    .int_in      (int_in),
    .rdata       (rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .timer_int   (timer_int),
    .exl         (exl)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] a,
                    input logic [31:0] e);
    cp0_addr = a;
    mfc0 = 1'b1;
    #1;
    chk(tag, rdata, e);
    mfc0 = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    mtc0 = 1'b1;
    cp0_addr = a;
    wdata = d;
    tick;
    mtc0 = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input int c);
    exp_t e;
    e.pc = pc;
    e.cyc = c;
    q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (redirect) begin
      if (q.size() == 0) begin
        chk("redir_spur", {31'b0, redirect}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("redir_pc", redirect_pc, e.pc);
        chk("redir_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    reset = 1'b1;
    exc_valid = 1'b0;
    exc_code = 5'd31;
    exc_pc = '0;
    mtc0 = 1'b0;
    mfc0 = 1'b0;
    eret = 1'b0;
    cp0_addr = '0;
    wdata = '0;
    int_in = '0;
    repeat (3) tick;
    reset = 1'b0;

    chk("rst_redir", {31'b0, redirect}, 32'd0);
    chk("rst_exl", {31'b0, exl}, 32'd0);
    chk("rst_tint", {31'b0, timer_int}, 32'd0);
    rd("rst_status", 5'd12, 32'h0000_FF01);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd("rst_compare", 5'd11, 32'hFFFF_FFFF);
    cp0_addr = 5'd12;
    #1;
    chk("rd_gated", rdata, 32'h0);
    tick;

    exc_valid = 1'b1;
    exc_code = 5'd8;
    exc_pc = 32'h40;
    push(32'h0000_F000, cyc + 1);
    tick;
    exc_code = 5'd9;
    exc_pc = 32'h80;
    chk("exc_exl", {31'b0, exl}, 32'd1);
    rd("exc_epc", 5'd14, 32'h40);
    rd("exc_cause", 5'd13, 32'h20);
    tick;
    exc_valid = 1'b0;
    exc_code = 5'd31;
    tick;
    rd("flush_cause", 5'd13, 32'h20);
    rd("flush_epc", 5'd14, 32'h40);

    eret = 1'b1;
    push(32'h40, cyc + 1);
    tick;
    eret = 1'b0;
    chk("eret_exl", {31'b0, exl}, 32'd0);
    repeat (2) tick;

    eret = 1'b1;
    exc_valid = 1'b1;
    exc_code = 5'd12;
    exc_pc = 32'h100;
    push(32'h0000_F000, cyc + 1);
    tick;
    eret = 1'b0;
    exc_valid = 1'b0;
    exc_code = 5'd31;
    chk("ex_er_exl", {31'b0, exl}, 32'd1);
    rd("ex_er_epc", 5'd14, 32'h100);
    rd("ex_er_cause", 5'd13, 32'h30);
    repeat (2) tick;

    exc_valid = 1'b1;
    exc_code = 5'd10;
    exc_pc = 32'h200;
    mtc0 = 1'b1;
    cp0_addr = 5'd14;
    wdata = 32'hDEAD_BEEF;
    push(32'h0000_F000, cyc + 1);
    tick;
    exc_valid = 1'b0;
    exc_code = 5'd31;
    mtc0 = 1'b0;
    chk("nest_exl", {31'b0, exl}, 32'd1);
    rd("nest_epc", 5'd14, 32'h100);
    rd("nest_cause", 5'd13, 32'h28);
    repeat (2) tick;

    eret = 1'b1;
    push(32'h100, cyc + 1);
    tick;
    eret = 1'b0;
    chk("eret2_exl", {31'b0, exl}, 32'd0);
    repeat (2) tick;

    wr(5'd12, 32'hFFFF_00FC);
    rd("msk_status", 5'd12, 32'h0);
    wr(5'd13, 32'hFFFF_FFFF);
    rd("msk_cause", 5'd13, 32'h328);
    wr(5'd13, 32'h0);
    rd("msk_cause0", 5'd13, 32'h28);
    wr(5'd5, 32'h1234);
    rd("unmapped", 5'd5, 32'h0);
    wr(5'd14, 32'hCAFE_0000);
    rd("epc_wr", 5'd14, 32'hCAFE_0000);
    wr(5'd12, 32'h0000_FF01);
    rd("status_back", 5'd12, 32'h0000_FF01);

    exc_pc = 32'h300;
    base = cyc;
    wr(5'd9, 32'h0);
    rd("cnt_wr_wins", 5'd9, 32'h0);
    push(32'h0000_F000, base + 20);
    wr(5'd11, 32'h10);
    repeat (15) tick;
    chk("tint_early", {31'b0, timer_int}, 32'd0);
    tick;
    chk("tint_set", {31'b0, timer_int}, 32'd1);
    repeat (2) tick;
    chk("tirq_exl", {31'b0, exl}, 32'd1);
    rd("tirq_epc", 5'd14, 32'h300);
    rd("tirq_cause", 5'd13, 32'h8000);
    repeat (2) tick;
    wr(5'd11, 32'hFFFF_FFFF);
    chk("tint_clr", {31'b0, timer_int}, 32'd0);
    tick;
    eret = 1'b1;
    push(32'h300, cyc + 1);
    tick;
    eret = 1'b0;
    chk("eret3_exl", {31'b0, exl}, 32'd0);
    repeat (2) tick;

    wr(5'd12, 32'h0000_FB01);
    int_in = 6'b000001;
    repeat (5) tick;
    chk("masked_exl", {31'b0, exl}, 32'd0);
    rd("masked_cause", 5'd13, 32'h400);
    exc_pc = 32'h500;
    mtc0 = 1'b1;
    cp0_addr = 5'd12;
    wdata = 32'h0000_FF01;
    push(32'h0000_F000, cyc + 2);
    tick;
    mtc0 = 1'b0;
    exc_pc = 32'h504;
    tick;
    chk("irq_exl", {31'b0, exl}, 32'd1);
    rd("irq_epc", 5'd14, 32'h504);
    int_in = '0;

    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mrst_redir", {31'b0, redirect}, 32'd0);
    chk("mrst_exl", {31'b0, exl}, 32'd0);
    chk("mrst_tint", {31'b0, timer_int}, 32'd0);
    rd("mrst_status", 5'd12, 32'h0000_FF01);
    rd("mrst_cause", 5'd13, 32'h0);
    rd("mrst_epc", 5'd14, 32'h0);
    rd("mrst_cmp", 5'd11, 32'hFFFF_FFFF);
    eret = 1'b1;
    push(32'h0, cyc + 1);
    tick;
    eret = 1'b0;
    chk("mrst_eret", {31'b0, exl}, 32'd0);
    repeat (4) tick;
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
